ddr_rdreq_arb: RTL

Responder side of the per-index DDR read request bitmap. It scans the `ddr_rd_req` vector in round-robin order and issues one DDR read command per pending index. It waits for the read data path to report completion, then returns a one-cycle `ddr_rd_ack` pulse on that index's bit, which clears the requester's flag. It sits between the ECM timer/request generator and the DDR command port of the memory controller wrapper.

---
 rtl/ddr_rdreq_arb.sv | 117 +++++++++++
 1 files changed

// File: rtl/ddr_rdreq_arb.sv
// Round-robin responder for the per-index DDR read request bitmap: one read command per pending index, ack pulse on completion.
// Optional read watchdog is compiled in with `define RD_TIMEOUT_EN.
module ddr_rdreq_arb #(
  parameter int                    TOTAL_INDEX    = 1024,
  parameter int                    ADDR_WIDTH     = 30,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    SLOT_SHIFT     = 8,
  parameter logic [5:0]            BURST_LEN      = 6'd63,
  parameter int                    TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TOTAL_INDEX-1:0] ddr_rd_req,
  output logic [TOTAL_INDEX-1:0] ddr_rd_ack,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [ADDR_WIDTH-1:0]  cmd_addr,
  output logic [5:0]             cmd_bl,
  output logic [9:0]             cur_index,
  input  logic                   rd_done,
  output logic                   busy,
  output logic                   rd_timeout_err
);

  typedef enum logic [3:0] {
    ST_SCAN = 4'b0001,
    ST_CMD  = 4'b0010,
    ST_WAIT = 4'b0100,
    ST_ACK  = 4'b1000
  } state_t;

  state_t     state, state_nxt;
  logic [9:0] scan_ptr;
  logic       req_hit;
  logic       wait_exit;

  if (TOTAL_INDEX < 2 || TOTAL_INDEX > 1024 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 8191) begin : g_param_check
    $error("ddr_rdreq_arb: parameter out of range");
  end

  function automatic logic [9:0] wrap_inc(input logic [9:0] idx);
    return (idx == 10'(TOTAL_INDEX - 1)) ? 10'd0 : idx + 10'd1;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] slot_addr(input logic [9:0] idx);
    return BASE_ADDR + (ADDR_WIDTH'(idx) << SLOT_SHIFT);
  endfunction

  assign req_hit = ddr_rd_req[scan_ptr];
  assign cmd_bl  = BURST_LEN;

`ifdef RD_TIMEOUT_EN
  logic [12:0] wd_cnt;
  logic        wd_expired;

  // Counter sits at zero outside WAIT, so it restarts on every WAIT entry.
  assign wd_expired = (wd_cnt == 13'(TIMEOUT_CYCLES));
  assign wait_exit  = rd_done || wd_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt         <= '0;
      rd_timeout_err <= 1'b0;
    end else begin
      wd_cnt         <= (state == ST_WAIT) ? wd_cnt + 13'd1 : 13'd0;
      rd_timeout_err <= (state == ST_WAIT) && !rd_done && (wd_cnt == 13'(TIMEOUT_CYCLES - 1));
    end
  end
`else
  assign wait_exit      = rd_done;
  assign rd_timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_SCAN: if (req_hit) state_nxt = ST_CMD;
      ST_CMD:  if (cmd_valid && cmd_ready) state_nxt = ST_WAIT;
      ST_WAIT: if (wait_exit) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_SCAN;
      default: state_nxt = ST_SCAN;
    endcase
  end

  // All outputs are registered; the ack vector is rebuilt from zero every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SCAN;
      scan_ptr   <= '0;
      cur_index  <= '0;
      cmd_addr   <= '0;
      cmd_valid  <= 1'b0;
      ddr_rd_ack <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != ST_SCAN);
      ddr_rd_ack <= '0;
      case (state)
        ST_SCAN: begin
          if (req_hit) begin
            cur_index <= scan_ptr;
            cmd_addr  <= slot_addr(scan_ptr);
            cmd_valid <= 1'b1;
          end else begin
            scan_ptr <= wrap_inc(scan_ptr);
          end
        end
        ST_CMD:  if (cmd_ready) cmd_valid <= 1'b0;
        ST_WAIT: if (wait_exit) ddr_rd_ack <= {{(TOTAL_INDEX-1){1'b0}}, 1'b1} << cur_index;
        ST_ACK:  scan_ptr <= wrap_inc(cur_index);
        default: ;
      endcase
    end
  end

endmodule
